// File: rtl/temporal_pulse_gen_if.sv
// Request/value/pulse bundle between a temporal_pulse_gen and its requester.
// The master drives the request and values; the slave returns ready, pulses and done.
interface temporal_pulse_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x_val;
  logic [WIDTH-1:0] y_val;
  logic             ready;
  logic             x_pulse;
  logic             y_pulse;
  logic             done;

  modport master (
    output start, x_val, y_val,
    input  ready, x_pulse, y_pulse, done
  );

  modport slave (
    input  start, x_val, y_val,
    output ready, x_pulse, y_pulse, done
  );
endinterface

// File: rtl/temporal_pulse_gen.sv
// Binary-to-temporal encoder: one flop-driven pulse per value, delayed from window start by that value.
// Optional build macro TEMPORAL_PULSE_GEN_LFSR_EN swaps the binary window counter for a maximal LFSR.
module temporal_pulse_gen #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_b,
  temporal_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] x_lat_reg, x_lat_next;
  logic [WIDTH-1:0] y_lat_reg, y_lat_next;
  logic             x_pulse_reg, x_pulse_next;
  logic             y_pulse_reg, y_pulse_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] cnt_step;
  logic             cnt_terminal;

`ifdef TEMPORAL_PULSE_GEN_LFSR_EN
  // Fibonacci taps (shift-left, feedback into bit 0) for maximal sequences.
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      default: tap_mask = 16'hD008;
    endcase
  endfunction

  localparam logic [15:0]      TAPS_ALL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED     = WIDTH'(1);

  assign cnt_step     = {cnt_reg[WIDTH-2:0], ^(cnt_reg & TAPS)};
  // Leave RUN on the state that precedes the seed, so every nonzero value is visited once.
  assign cnt_terminal = (cnt_step == SEED);
`else
  localparam logic [WIDTH-1:0] SEED = '0;

  assign cnt_step     = cnt_reg + WIDTH'(1);
  assign cnt_terminal = (cnt_reg == {WIDTH{1'b1}});
`endif

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      x_lat_reg   <= '0;
      y_lat_reg   <= '0;
      x_pulse_reg <= 1'b0;
      y_pulse_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      x_lat_reg   <= x_lat_next;
      y_lat_reg   <= y_lat_next;
      x_pulse_reg <= x_pulse_next;
      y_pulse_reg <= y_pulse_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    x_lat_next   = x_lat_reg;
    y_lat_next   = y_lat_reg;
    x_pulse_next = 1'b0;
    y_pulse_next = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          x_lat_next = bus.x_val;
          y_lat_next = bus.y_val;
          cnt_next   = SEED;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        // Pulse registers are loaded from the compare, so outputs trail the count by one edge.
        x_pulse_next = (cnt_reg == x_lat_reg);
        y_pulse_next = (cnt_reg == y_lat_reg);
        cnt_next     = cnt_step;
        if (cnt_terminal) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.ready   = (state_reg == S_IDLE);
  assign bus.x_pulse = x_pulse_reg;
  assign bus.y_pulse = y_pulse_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_temporal_pulse_gen.sv
// Bench for temporal_pulse_gen (binary-counter build, WIDTH=4): directed windows with literal
// expectations plus a per-cycle comparison against an event-time model.
module tb_temporal_pulse_gen;
  localparam int W = 4;
  localparam int N = 1 << W;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  temporal_pulse_gen_if #(.WIDTH(W)) bus ();

  temporal_pulse_gen #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: a window is an acceptance edge number plus latched values; outputs follow from offsets.
  int edge_n = 0;
  int m_t0 = 0;
  int m_lx = 0;
  int m_ly = 0;
  bit m_active = 1'b0;
  bit m_ready = 1'b1;
  bit model_en = 1'b0;
  bit exp_x, exp_y, exp_done, exp_ready;

  always @(posedge clk) begin
    int off;
    edge_n = edge_n + 1;
    if (!rst_b) begin
      m_active = 1'b0;
      model_en = 1'b1;
    end else if (m_ready && bus.start) begin
      m_active = 1'b1;
      m_t0 = edge_n;
      m_lx = int'(bus.x_val);
      m_ly = int'(bus.y_val);
    end
    off = edge_n - m_t0;
    exp_x     = m_active && (off == 1 + m_lx);
    exp_y     = m_active && (off == 1 + m_ly);
    exp_done  = m_active && (off == N + 1);
    exp_ready = !m_active || (off >= N + 1);
    m_ready   = exp_ready;
  end

  task automatic chk(input string name, input int k, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s k=%0d: got %b, expected %b", name, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_en) begin
      chk("model_x_pulse", edge_n, bus.x_pulse, exp_x);
      chk("model_y_pulse", edge_n, bus.y_pulse, exp_y);
      chk("model_done",    edge_n, bus.done,    exp_done);
      chk("model_ready",   edge_n, bus.ready,   exp_ready);
    end
  end

  function automatic bit hit(input int k, input int l[3]);
    return (k == l[0]) || (k == l[1]) || (k == l[2]);
  endfunction

  // Waits for the negedge after E(k) and checks hand-computed literal expectations.
  task automatic step(input int k, input int xs[3], input int ys[3], input int ds[3],
                      input int rdy0_max, input int rdy1_min);
    @(negedge clk);
    chk("lit_x_pulse", k, bus.x_pulse, hit(k, xs));
    chk("lit_y_pulse", k, bus.y_pulse, hit(k, ys));
    chk("lit_done",    k, bus.done,    hit(k, ds));
    if (k <= rdy0_max) chk("lit_ready_low", k, bus.ready, 1'b0);
    if (k >= rdy1_min) chk("lit_ready_high", k, bus.ready, 1'b1);
  endtask

  task automatic begin_window(input int xv, input int yv);
    bus.start = 1'b1;
    bus.x_val = W'(xv);
    bus.y_val = W'(yv);
    $display("window request x_val=%0d y_val=%0d at t=%0t", xv, yv, $time);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.x_val = '0;
    bus.y_val = '0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready",   0, bus.ready,   1'b1);
    chk("reset_x_pulse", 0, bus.x_pulse, 1'b0);
    chk("reset_y_pulse", 0, bus.y_pulse, 1'b0);
    chk("reset_done",    0, bus.done,    1'b0);
    rst_b = 1'b1;
    @(negedge clk);

    // Basic window x=3, y=9.
    begin_window(3, 9);
    for (int k = 0; k <= 20; k++) begin
      step(k, '{4, -1, -1}, '{10, -1, -1}, '{17, -1, -1}, 16, 18);
      if (k == 0) bus.start = 1'b0;
    end

    // Extremes: both zero, then both maximal.
    begin_window(0, 0);
    for (int k = 0; k <= 20; k++) begin
      step(k, '{1, -1, -1}, '{1, -1, -1}, '{17, -1, -1}, 16, 18);
      if (k == 0) bus.start = 1'b0;
    end
    begin_window(15, 15);
    for (int k = 0; k <= 20; k++) begin
      step(k, '{16, -1, -1}, '{16, -1, -1}, '{17, -1, -1}, 16, 18);
      if (k == 0) bus.start = 1'b0;
    end

    // Start during RUN is ignored; input changes after acceptance do not matter.
    begin_window(3, 9);
    for (int k = 0; k <= 20; k++) begin
      step(k, '{4, -1, -1}, '{10, -1, -1}, '{17, -1, -1}, 16, 18);
      if (k == 0) bus.start = 1'b0;
      if (k == 4) begin
        bus.start = 1'b1;
        bus.x_val = 4'd1;
        bus.y_val = 4'd2;
      end
      if (k == 5) bus.start = 1'b0;
    end

    // Reset at E6 aborts a window that would pulse at E9.
    begin_window(8, 8);
    for (int k = 0; k <= 20; k++) begin
      step(k, '{-1, -1, -1}, '{-1, -1, -1}, '{-1, -1, -1}, 5, 6);
      if (k == 0) bus.start = 1'b0;
      if (k == 5) rst_b = 1'b0;
      if (k == 6) rst_b = 1'b1;
    end

    // Back-to-back windows with start held; period 18.
    begin_window(2, 0);
    for (int k = 0; k <= 56; k++) begin
      step(k, '{3, 24, 44}, '{1, 19, 37}, '{17, 35, 53}, 16, 54);
      if (k == 0) bus.x_val = 4'd5;
      if (k == 18) bus.x_val = 4'd7;
      if (k == 36) bus.start = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
